copy_opt_scheduler: RTL

// - Shares the single command argument copy-optimisation engine between two requesters:
//   the command-in path (queue_select=0) and the internal command-in path (queue_select=1).
// - Round-robin arbitration; latches the winner's operands; pulses the engine start;

---
 rtl/copy_opt_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/copy_opt_scheduler.sv
// Round-robin scheduler sharing one copy-optimisation engine between the cmd-in
// and internal cmd-in requesters: latch operands, pulse start, await finish, ack.
module copy_opt_scheduler #(
    parameter int SUBQUEUE_BITS = 6,
    parameter int TIMEOUT       = 0,
    parameter int DBG_REGS      = 0
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     cmdin_req,
    input  logic [SUBQUEUE_BITS-1:0] cmdin_first_idx,
    input  logic [SUBQUEUE_BITS-1:0] cmdin_first_next_idx,
    input  logic [3:0]               cmdin_num_args,
    input  logic [1:0]               cmdin_cmd_type,
    output logic                     cmdin_ack,

    input  logic                     intcmdin_req,
    input  logic [SUBQUEUE_BITS-1:0] intcmdin_first_idx,
    input  logic [SUBQUEUE_BITS-1:0] intcmdin_first_next_idx,
    input  logic [3:0]               intcmdin_num_args,
    input  logic [1:0]               intcmdin_cmd_type,
    output logic                     intcmdin_ack,

    output logic                     opt_start,
    output logic [SUBQUEUE_BITS-1:0] opt_first_idx,
    output logic [SUBQUEUE_BITS-1:0] opt_first_next_idx,
    output logic [3:0]               opt_num_args,
    output logic [1:0]               opt_cmd_type,
    output logic                     opt_queue_select,
    input  logic                     opt_finished,

    output logic                     timeout_err,
    output logic [31:0]              grants_cmdin,
    output logic [31:0]              grants_intcmdin,
    output logic [31:0]              skips,
    output logic [31:0]              timeouts
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        WAIT  = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam bit          DBG_EN      = (DBG_REGS != 0);
    localparam bit          WDOG_EN     = (TIMEOUT != 0);
    localparam logic [15:0] WDOG_LAST   = WDOG_EN ? 16'(TIMEOUT - 1) : 16'd0;

    state_t      state;
    logic        last_grant;
    logic [15:0] wdog;

    logic                     pick_int;
    logic [SUBQUEUE_BITS-1:0] sel_first_idx;
    logic [SUBQUEUE_BITS-1:0] sel_first_next_idx;
    logic [3:0]               sel_num_args;
    logic [1:0]               sel_cmd_type;

    // On a tie the requester that did not win last time is chosen.
    assign pick_int           = intcmdin_req && (!cmdin_req || !last_grant);
    assign sel_first_idx      = pick_int ? intcmdin_first_idx      : cmdin_first_idx;
    assign sel_first_next_idx = pick_int ? intcmdin_first_next_idx : cmdin_first_next_idx;
    assign sel_num_args       = pick_int ? intcmdin_num_args       : cmdin_num_args;
    assign sel_cmd_type       = pick_int ? intcmdin_cmd_type       : cmdin_cmd_type;

    // NOTE: every register here is updated with <= so all state moves together on
    // the edge; a blocking assignment would let later statements see new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            last_grant         <= 1'b1;
            wdog               <= '0;
            opt_start          <= 1'b0;
            opt_first_idx      <= '0;
            opt_first_next_idx <= '0;
            opt_num_args       <= '0;
            opt_cmd_type       <= '0;
            opt_queue_select   <= 1'b0;
            cmdin_ack          <= 1'b0;
            intcmdin_ack       <= 1'b0;
            timeout_err        <= 1'b0;
            grants_cmdin       <= '0;
            grants_intcmdin    <= '0;
            skips              <= '0;
            timeouts           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdin_req || intcmdin_req) begin
                        opt_first_idx      <= sel_first_idx;
                        opt_first_next_idx <= sel_first_next_idx;
                        opt_num_args       <= sel_num_args;
                        opt_cmd_type       <= sel_cmd_type;
                        opt_queue_select   <= pick_int;
                        last_grant         <= pick_int;
                        if (DBG_EN) begin
                            if (pick_int) grants_intcmdin <= grants_intcmdin + 32'd1;
                            else          grants_cmdin    <= grants_cmdin + 32'd1;
                        end
                        if (sel_num_args == 4'd0) begin
                            // Nothing to optimise: complete without touching the engine.
                            cmdin_ack    <= !pick_int;
                            intcmdin_ack <= pick_int;
                            if (DBG_EN) skips <= skips + 32'd1;
                            state <= DONE;
                        end else begin
                            opt_start <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    opt_start <= 1'b0;
                    wdog      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (opt_finished) begin
                        cmdin_ack    <= !opt_queue_select;
                        intcmdin_ack <= opt_queue_select;
                        state        <= DONE;
                    end else if (WDOG_EN && wdog == WDOG_LAST) begin
                        cmdin_ack    <= !opt_queue_select;
                        intcmdin_ack <= opt_queue_select;
                        timeout_err  <= 1'b1;
                        if (DBG_EN) timeouts <= timeouts + 32'd1;
                        state        <= DONE;
                    end else if (wdog != 16'hFFFF) begin
                        wdog <= wdog + 16'd1;
                    end
                end
                DONE: begin
                    cmdin_ack    <= 1'b0;
                    intcmdin_ack <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
